// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32I-subset core: one shared ALU and one unified memory port are
// sequenced by a control FSM; an unknown opcode parks the core in HALT until rst.
module multi_cycle_core #(
  parameter int ADDR_W   = 16,
  parameter int RESET_PC = 0,
  parameter int NREGS    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_dbg
);
  localparam int RW = $clog2(NREGS);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWR, EXECR, EXECI, WBALU, WBMEM, BRANCH, HALT
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] pc, old_pc;
  logic [31:0]       ir, a_reg, b_reg, imm, alu_out, mdr;
  logic [31:0]       imm_dec, alu_b, alu_y;
  logic [31:0]       rf [NREGS];
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [RW-1:0]     rd, rs1, rs2;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign rd        = ir[7 +: RW];
  assign rs1       = ir[15 +: RW];
  assign rs2       = ir[20 +: RW];
  assign mem_wdata = b_reg;
  assign halted    = (state == HALT);
  assign pc_dbg    = pc;

  always_comb begin
    case (opcode)
      OP_SW:   imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BEQ:  imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default: imm_dec = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  // Shared ALU; MEMADR always adds because lw/sw funct3 would otherwise decode as slt.
  always_comb begin
    alu_b = (state == EXECR) ? b_reg : imm;
    alu_y = a_reg + alu_b;
    if (state != MEMADR) begin
      case (funct3)
        3'b000:  alu_y = (state == EXECR && ir[30]) ? a_reg - alu_b : a_reg + alu_b;
        3'b010:  alu_y = {31'd0, $signed(a_reg) < $signed(alu_b)};
        3'b110:  alu_y = a_reg | alu_b;
        3'b111:  alu_y = a_reg & alu_b;
        default: alu_y = a_reg + alu_b;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    retire     = 1'b0;
    mem_addr   = {pc[ADDR_W-1:2], 2'b00};
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_IMM:       state_next = EXECI;
          OP_REG:       state_next = EXECR;
          OP_BEQ:       state_next = BRANCH;
          default:      state_next = HALT;
        endcase
      end
      MEMADR: state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD: begin
        mem_req  = 1'b1;
        mem_addr = {alu_out[ADDR_W-1:2], 2'b00};
        if (mem_ready) state_next = WBMEM;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {alu_out[ADDR_W-1:2], 2'b00};
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      EXECR, EXECI: state_next = WBALU;
      WBALU, WBMEM, BRANCH: begin
        retire     = 1'b1;
        state_next = FETCH;
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
    // A request still showing while rst is high would be abandoned anyway.
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      retire  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= ADDR_W'(RESET_PC);
      old_pc  <= '0;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      imm     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      state <= state_next;
      case (state)
        FETCH: if (mem_ready) begin
          ir     <= mem_rdata;
          old_pc <= pc;
          pc     <= pc + ADDR_W'(4);
        end
        DECODE: begin
          a_reg <= rf[rs1];
          b_reg <= rf[rs2];
          imm   <= imm_dec;
        end
        MEMADR, EXECR, EXECI: alu_out <= alu_y;
        MEMRD:  if (mem_ready) mdr <= mem_rdata;
        WBALU:  if (rd != '0) rf[rd] <= alu_out;
        WBMEM:  if (rd != '0) rf[rd] <= mdr;
        BRANCH: if (a_reg == b_reg) pc <= old_pc + imm[ADDR_W-1:0];
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_core.sv
// Bench for multi_cycle_core: directed and random programs are run on the core and
// on an instruction-level model that predicts memory contents and retire timing.
`timescale 1ns/1ps
module tb_multi_cycle_core;
  localparam int ADDR_W   = 16;
  localparam int RESET_PC = 'h40;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_req, mem_we, mem_ready, retire, halted;
  logic [ADDR_W-1:0] mem_addr, pc_dbg;
  logic [31:0] mem_wdata, mem_rdata;

  multi_cycle_core #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .halted(halted), .pc_dbg(pc_dbg)
  );

  always #5 clk = ~clk;

  logic [31:0] tb_mem [1024];
  logic [31:0] model_mem [1024];
  logic [31:0] prog [$];
  int wait_cfg = 0;
  int wait_cnt = 0;
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  // Memory answers after wait_cfg wait cycles on every request.
  assign mem_ready = mem_req && (wait_cnt >= wait_cfg);
  assign mem_rdata = tb_mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (rst) cyc <= 0; else cyc <= cyc + 1;
    if (rst || !mem_req || mem_ready) wait_cnt <= 0; else wait_cnt <= wait_cnt + 1;
  end

  logic prev_req = 1'b0, prev_ready = 1'b0, prev_we = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;
  int stab_viol = 0;
  int wait_seen = 0;
  always @(negedge clk) begin
    if (!rst && prev_req && !prev_ready) begin
      wait_seen <= wait_seen + 1;
      if (mem_req !== 1'b1 || mem_addr !== prev_addr || mem_we !== prev_we ||
          mem_wdata !== prev_wdata) stab_viol <= stab_viol + 1;
    end
    prev_req   <= mem_req && !rst;
    prev_ready <= mem_ready;
    prev_we    <= mem_we;
    prev_addr  <= mem_addr;
    prev_wdata <= mem_wdata;
  end

  function automatic logic [31:0] enc_i(input logic [2:0] f3, input int rd, input int rs1,
                                        input int imm, input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(input bit sub, input logic [2:0] f3, input int rd,
                                        input int rs1, input int rs2);
    return {1'b0, sub, 5'd0, 5'(rs2), 5'(rs1), f3, 5'(rd), OP_REG};
  endfunction

  function automatic logic [31:0] enc_s(input int rs2, input int rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], OP_SW};
  endfunction

  function automatic logic [31:0] enc_b(input int rs1, input int rs2, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'b000, v[4:1], v[11], OP_BEQ};
  endfunction

  function automatic logic [31:0] model_alu(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b, input bit sub);
    case (f3)
      3'b000:  return sub ? a - b : a + b;
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b110:  return a | b;
      3'b111:  return a & b;
      default: return a + b;
    endcase
  endfunction

  task automatic poke(input int idx, input logic [31:0] w);
    tb_mem[idx]    = w;
    model_mem[idx] = w;
  endtask

  // Unwritten memory holds an illegal opcode so stray control flow halts.
  task automatic load_prog();
    for (int i = 0; i < 1024; i++) poke(i, 32'h0000007F);
    for (int i = 0; i < prog.size(); i++) poke(RESET_PC / 4 + i, prog[i]);
  endtask

  int exp_retire [$];
  logic [ADDR_W-1:0] exp_reads [$];
  int exp_halt_cyc;

  // ISA-level interpreter; timing from the per-class latency table plus waits.
  task automatic model_run(input int w);
    logic [31:0] x [32];
    logic [31:0] ins, a, b, immi, imms, immb, addr;
    logic [ADDR_W-1:0] pc;
    int t, lat;
    exp_retire.delete();
    exp_reads.delete();
    exp_halt_cyc = -1;
    for (int i = 0; i < 32; i++) x[i] = 32'd0;
    pc = ADDR_W'(RESET_PC);
    t = 0;
    for (int n = 0; n < 1000; n++) begin
      ins = model_mem[pc[11:2]];
      exp_reads.push_back(pc);
      a = x[ins[19:15]];
      b = x[ins[24:20]];
      immi = {{20{ins[31]}}, ins[31:20]};
      imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      case (ins[6:0])
        OP_IMM: begin
          x[ins[11:7]] = model_alu(ins[14:12], a, immi, 1'b0);
          lat = 4 + w; pc = pc + 16'd4;
        end
        OP_REG: begin
          x[ins[11:7]] = model_alu(ins[14:12], a, b, ins[30]);
          lat = 4 + w; pc = pc + 16'd4;
        end
        OP_SW: begin
          addr = a + imms;
          model_mem[addr[11:2]] = b;
          lat = 4 + 2 * w; pc = pc + 16'd4;
        end
        OP_LW: begin
          addr = a + immi;
          exp_reads.push_back({addr[ADDR_W-1:2], 2'b00});
          x[ins[11:7]] = model_mem[addr[11:2]];
          lat = 5 + 2 * w; pc = pc + 16'd4;
        end
        OP_BEQ: begin
          lat = 3 + w;
          pc = (a == b) ? pc + immb[ADDR_W-1:0] : pc + 16'd4;
        end
        default: begin
          exp_halt_cyc = t + w + 2;
          return;
        end
      endcase
      x[0] = 32'd0;
      exp_retire.push_back(t + lat - 1);
      t = t + lat;
    end
  endtask

  int dut_retire [$];
  logic [ADDR_W-1:0] dut_reads [$];
  int dut_halt_cyc;
  bit dut_timeout;
  int stab_delta, wait_delta;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs the loaded program until halt, recording retires, reads and stores.
  task automatic run_dut(input int w);
    int stab_base, wait_base;
    dut_retire.delete();
    dut_reads.delete();
    dut_halt_cyc = -1;
    dut_timeout = 1'b0;
    wait_cfg = w;
    stab_base = stab_viol;
    wait_base = wait_seen;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (retire) dut_retire.push_back(cyc);
      if (mem_req && mem_ready && !mem_we) dut_reads.push_back(mem_addr);
      if (mem_req && mem_ready && mem_we) tb_mem[mem_addr[11:2]] = mem_wdata;
      if (halted) begin
        dut_halt_cyc = cyc;
        break;
      end
      if (i == 2999) dut_timeout = 1'b1;
    end
    stab_delta = stab_viol - stab_base;
    wait_delta = wait_seen - wait_base;
  endtask

  task automatic test_reset();
    prog.delete();
    prog.push_back(enc_i(3'b000, 0, 0, 0, OP_IMM));
    load_prog();
    wait_cfg = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) $display("[TB] FAIL reset_req: got %b want 0", mem_req); else n_pass++;
    n_checks++; if (retire !== 1'b0) $display("[TB] FAIL reset_retire: got %b want 0", retire); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("[TB] FAIL reset_halted: got %b want 0", halted); else n_pass++;
    n_checks++; if (pc_dbg !== 16'h0040) $display("[TB] FAIL reset_pc: got %h want 0040", pc_dbg); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1) $display("[TB] FAIL first_req: got %b want 1", mem_req); else n_pass++;
    n_checks++; if (mem_addr !== 16'h0040) $display("[TB] FAIL first_addr: got %h want 0040", mem_addr); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("[TB] FAIL first_we: got %b want 0", mem_we); else n_pass++;
    @(negedge clk);
    n_checks++; if (pc_dbg !== 16'h0044) $display("[TB] FAIL pc_after_fetch: got %h want 0044", pc_dbg); else n_pass++;
    n_checks++; if (mem_req !== 1'b0) $display("[TB] FAIL decode_req: got %b want 0", mem_req); else n_pass++;
  endtask

  task automatic test_alu_program();
    prog.delete();
    prog.push_back(enc_i(3'b000, 1, 0, 5, OP_IMM));
    prog.push_back(enc_i(3'b000, 2, 0, 7, OP_IMM));
    prog.push_back(enc_r(1'b0, 3'b000, 3, 1, 2));
    prog.push_back(enc_r(1'b1, 3'b000, 4, 1, 2));
    prog.push_back(enc_s(3, 0, 'h400));
    prog.push_back(enc_s(4, 0, 'h404));
    load_prog();
    model_run(0);
    run_dut(0);
    n_checks++; if (dut_timeout) $display("[TB] FAIL alu_timeout: got timeout want halt"); else n_pass++;
    n_checks++; if (tb_mem[256] !== 32'd12) $display("[TB] FAIL alu_x3: got %h want 0000000c", tb_mem[256]); else n_pass++;
    n_checks++; if (tb_mem[257] !== 32'hFFFFFFFE) $display("[TB] FAIL alu_x4: got %h want fffffffe", tb_mem[257]); else n_pass++;
    for (int k = 1; k < 4; k++) begin
      n_checks++;
      if (dut_retire.size() < 4 || dut_retire[k] - dut_retire[k-1] != 4)
        $display("[TB] FAIL alu_spacing%0d: got %0d retires want gap 4", k, dut_retire.size());
      else n_pass++;
    end
    for (int k = 0; k < exp_retire.size(); k++) begin
      n_checks++;
      if (k >= dut_retire.size() || dut_retire[k] != exp_retire[k])
        $display("[TB] FAIL alu_retire%0d: got %0d want cycle %0d", k, (k < dut_retire.size()) ? dut_retire[k] : -1, exp_retire[k]);
      else n_pass++;
    end
    n_checks++; if (dut_halt_cyc != exp_halt_cyc) $display("[TB] FAIL alu_halt: got %0d want %0d", dut_halt_cyc, exp_halt_cyc); else n_pass++;
  endtask

  task automatic test_x0_slt();
    prog.delete();
    prog.push_back(enc_i(3'b000, 0, 0, 9, OP_IMM));
    prog.push_back(enc_i(3'b000, 1, 0, 5, OP_IMM));
    prog.push_back(enc_i(3'b000, 2, 0, -1, OP_IMM));
    prog.push_back(enc_r(1'b0, 3'b010, 6, 2, 1));
    prog.push_back(enc_s(0, 0, 'h400));
    prog.push_back(enc_s(6, 0, 'h404));
    load_prog();
    model_run(1);
    run_dut(1);
    n_checks++; if (tb_mem[256] !== 32'd0) $display("[TB] FAIL x0_write: got %h want 00000000", tb_mem[256]); else n_pass++;
    n_checks++; if (tb_mem[257] !== 32'd1) $display("[TB] FAIL slt_signed: got %h want 00000001", tb_mem[257]); else n_pass++;
    n_checks++; if (dut_retire.size() != exp_retire.size()) $display("[TB] FAIL x0_retires: got %0d want %0d", dut_retire.size(), exp_retire.size()); else n_pass++;
  endtask

  task automatic test_mem_wait();
    prog.delete();
    prog.push_back(enc_i(3'b000, 3, 0, 12, OP_IMM));
    prog.push_back(enc_s(3, 0, 8));
    prog.push_back(enc_i(3'b010, 5, 0, 8, OP_LW));
    prog.push_back(enc_s(5, 0, 'h400));
    load_prog();
    model_run(3);
    run_dut(3);
    n_checks++; if (dut_timeout) $display("[TB] FAIL mem_timeout: got timeout want halt"); else n_pass++;
    n_checks++; if (tb_mem[2] !== 32'd12) $display("[TB] FAIL sw_word2: got %h want 0000000c", tb_mem[2]); else n_pass++;
    n_checks++; if (tb_mem[256] !== 32'd12) $display("[TB] FAIL lw_x5: got %h want 0000000c", tb_mem[256]); else n_pass++;
    n_checks++;
    if (dut_retire.size() < 3 || dut_retire[2] - dut_retire[1] != 11)
      $display("[TB] FAIL lw_latency: got %0d retires want lw done 11 cycles after sw", dut_retire.size());
    else n_pass++;
    n_checks++; if (stab_delta != 0) $display("[TB] FAIL req_stable: got %0d violations want 0", stab_delta); else n_pass++;
    n_checks++; if (wait_delta != 24) $display("[TB] FAIL wait_cycles: got %0d want 24", wait_delta); else n_pass++;
    for (int k = 0; k < exp_retire.size(); k++) begin
      n_checks++;
      if (k >= dut_retire.size() || dut_retire[k] != exp_retire[k])
        $display("[TB] FAIL mem_retire%0d: got %0d want cycle %0d", k, (k < dut_retire.size()) ? dut_retire[k] : -1, exp_retire[k]);
      else n_pass++;
    end
  endtask

  task automatic test_branch(input bit taken);
    prog.delete();
    prog.push_back(enc_i(3'b000, 1, 0, 3, OP_IMM));
    prog.push_back(enc_i(3'b000, 2, 0, 4, OP_IMM));
    prog.push_back(enc_b(0, 0, -'h38));
    load_prog();
    poke(4, taken ? enc_b(1, 1, -8) : enc_b(1, 2, -8));
    model_run(0);
    run_dut(0);
    n_checks++;
    if (dut_reads.size() != 5 || dut_reads[4] !== (taken ? 16'h0008 : 16'h0014))
      $display("[TB] FAIL beq_target_%0d: got %0d reads want last %h", taken, dut_reads.size(), taken ? 16'h0008 : 16'h0014);
    else n_pass++;
    for (int k = 0; k < exp_reads.size(); k++) begin
      n_checks++;
      if (k >= dut_reads.size() || dut_reads[k] !== exp_reads[k])
        $display("[TB] FAIL beq_read%0d: got %h want %h", k, (k < dut_reads.size()) ? dut_reads[k] : 16'hxxxx, exp_reads[k]);
      else n_pass++;
    end
    n_checks++; if (dut_halt_cyc != exp_halt_cyc) $display("[TB] FAIL beq_halt: got %0d want %0d", dut_halt_cyc, exp_halt_cyc); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int w;
      w = $urandom_range(0, 2);
      prog.delete();
      for (int r = 1; r < 8; r++) prog.push_back(enc_i(3'b000, r, 0, $urandom_range(0, 4095) - 2048, OP_IMM));
      for (int n = 0; n < 10; n++) begin
        int kind, rd, rs1, rs2;
        logic [2:0] f3s [4];
        f3s[0] = 3'b000; f3s[1] = 3'b111; f3s[2] = 3'b110; f3s[3] = 3'b010;
        kind = $urandom_range(0, 8);
        rd = $urandom_range(0, 7);
        rs1 = $urandom_range(0, 7);
        rs2 = $urandom_range(0, 7);
        if (kind < 4) prog.push_back(enc_i(f3s[kind], rd, rs1, $urandom_range(0, 4095) - 2048, OP_IMM));
        else if (kind == 4) prog.push_back(enc_r(1'b1, 3'b000, rd, rs1, rs2));
        else prog.push_back(enc_r(1'b0, f3s[kind - 5], rd, rs1, rs2));
      end
      for (int r = 1; r < 8; r++) prog.push_back(enc_s(r, 0, 'h400 + 4 * (r - 1)));
      load_prog();
      model_run(w);
      run_dut(w);
      n_checks++; if (dut_retire.size() != exp_retire.size()) $display("[TB] FAIL rnd%0d_count: got %0d want %0d", it, dut_retire.size(), exp_retire.size()); else n_pass++;
      for (int r = 0; r < 7; r++) begin
        n_checks++;
        if (tb_mem[256 + r] !== model_mem[256 + r])
          $display("[TB] FAIL rnd%0d_x%0d: got %h want %h", it, r + 1, tb_mem[256 + r], model_mem[256 + r]);
        else n_pass++;
      end
      n_checks++;
      if (dut_retire.size() == 0 || dut_retire[dut_retire.size() - 1] != exp_retire[exp_retire.size() - 1])
        $display("[TB] FAIL rnd%0d_timing: got %0d retires want last at %0d", it, dut_retire.size(), exp_retire[exp_retire.size() - 1]);
      else n_pass++;
      n_checks++; if (dut_halt_cyc != exp_halt_cyc) $display("[TB] FAIL rnd%0d_halt: got %0d want %0d", it, dut_halt_cyc, exp_halt_cyc); else n_pass++;
    end
  endtask

  task automatic test_illegal();
    prog.delete();
    prog.push_back(32'h0000007F);
    load_prog();
    wait_cfg = 0;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      n_checks++;
      if (halted !== (c >= 2)) $display("[TB] FAIL illegal_halted_c%0d: got %b want %b", c, halted, c >= 2); else n_pass++;
      n_checks++;
      if (retire !== 1'b0) $display("[TB] FAIL illegal_retire_c%0d: got %b want 0", c, retire); else n_pass++;
      if (c >= 2) begin
        n_checks++;
        if (mem_req !== 1'b0) $display("[TB] FAIL halt_req_c%0d: got %b want 0", c, mem_req); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    n_checks++; if (halted !== 1'b1) $display("[TB] FAIL pre_halted: got %b want 1", halted); else n_pass++;
    prog.delete();
    prog.push_back(enc_i(3'b010, 5, 0, 'h400, OP_LW));
    load_prog();
    wait_cfg = 10;
    do_reset();
    @(negedge clk);
    n_checks++; if (halted !== 1'b0) $display("[TB] FAIL halt_cleared: got %b want 0", halted); else n_pass++;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 16'h0400) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++; if (!found) $display("[TB] FAIL memrd_seen: got none want req at 0400"); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (mem_req !== 1'b1) $display("[TB] FAIL memrd_hold: got %b want 1", mem_req); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b1;
    wait_cfg = 0;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) $display("[TB] FAIL abandon_req: got %b want 0", mem_req); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_addr !== 16'h0040 || mem_req !== 1'b1) $display("[TB] FAIL refetch: got req %b addr %h want 1 0040", mem_req, mem_addr); else n_pass++;
    n_checks++; if (retire !== 1'b0) $display("[TB] FAIL refetch_retire: got %b want 0", retire); else n_pass++;
    @(negedge clk);
    n_checks++; if (pc_dbg !== 16'h0044) $display("[TB] FAIL refetch_pc: got %h want 0044", pc_dbg); else n_pass++;
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL global_timeout: got no finish want finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    test_reset();
    test_alu_program();
    test_x0_slt();
    test_mem_wait();
    test_branch(1'b1);
    test_branch(1'b0);
    test_random();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
